// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD add/subtract unit: one decimal digit per clock, LSD first,
// with a start/done handshake and results registered for the display path.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Sub,
    input  logic                  Cin,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   Sum,
    output logic                  Cout,
    output logic                  Err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   acc_reg;
    logic           sub_reg;
    logic           carry_reg;
    logic           err_reg;
    logic [CW-1:0]  cnt_reg;

    logic           busy_reg;
    logic           done_reg;
    logic [W-1:0]   sum_reg;
    logic           cout_reg;
    logic           err_out_reg;

    logic [3:0]     a_dig;
    logic [3:0]     b_dig;
    logic [3:0]     b_eff;
    logic [4:0]     t_raw;
    logic [3:0]     dig_next;
    logic           carry_next;
    logic           err_next;
    logic [W+3:0]   acc_shift;
    logic [W-1:0]   acc_next;

    // Operands shift right each digit, so the current digit always sits in bits [3:0].
    always_comb begin
        a_dig      = a_reg[3:0];
        b_dig      = b_reg[3:0];
        b_eff      = sub_reg ? (4'd9 - b_dig) : b_dig;
        t_raw      = {1'b0, a_dig} + {1'b0, b_eff} + {4'd0, carry_reg};
        dig_next   = t_raw[3:0];
        carry_next = 1'b0;
        if (t_raw > 5'd9) begin
            dig_next   = t_raw[3:0] + 4'd6;
            carry_next = 1'b1;
        end
        err_next   = err_reg | (a_dig > 4'd9) | (b_dig > 4'd9);
        // New digit enters at the top; after DIGITS shifts digit 0 lands at the bottom.
        acc_shift  = {dig_next, acc_reg};
        acc_next   = acc_shift[W+3:4];
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            sub_reg     <= 1'b0;
            carry_reg   <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
            err_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (Start) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        sub_reg   <= Sub;
                        carry_reg <= Sub ? 1'b1 : Cin;
                        err_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    a_reg     <= a_reg >> 4;
                    b_reg     <= b_reg >> 4;
                    acc_reg   <= acc_next;
                    carry_reg <= carry_next;
                    err_reg   <= err_next;
                    if (cnt_reg == LAST_DIGIT) begin
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        sum_reg     <= acc_next;
                        cout_reg    <= carry_next;
                        err_out_reg <= err_next;
                        state_reg   <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign Busy = busy_reg;
    assign Done = done_reg;
    assign Sum  = sum_reg;
    assign Cout = cout_reg;
    assign Err  = err_out_reg;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomised and directed bench for bcd_serial_adder against an integer-arithmetic
// decimal reference model.
module tb_bcd_serial_adder;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         Clock;
    logic         Reset;
    logic         Start;
    logic         Sub;
    logic         Cin;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Err;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .Sub   (Sub),
        .Cin   (Cin),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Err   (Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic longint bcd2int(input logic [W-1:0] x);
        longint v = 0;
        for (int i = D - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        longint       t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit all_valid(input logic [W-1:0] x);
        for (int i = 0; i < D; i++) if (x[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] r;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 7) == 0)
            r[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    // Full handshake for one operation; junk=1 keeps Start high with other operands while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, input bit junk);
        longint       p = 1;
        longint       va;
        longint       vb;
        longint       v;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        bit           valid;
        for (int i = 0; i < D; i++) p = p * 10;
        va    = bcd2int(a);
        vb    = bcd2int(b);
        valid = all_valid(a) && all_valid(b);
        if (s) begin
            exp_cout = (va >= vb);
            v        = va - vb + p;
        end else begin
            v        = va + vb + longint'(c);
            exp_cout = (v >= p);
        end
        exp_sum = int2bcd(v % p);

        @(negedge Clock);
        A = a; B = b; Sub = s; Cin = c; Start = 1'b1;
        @(negedge Clock);
        for (int i = 0; i < D; i++) begin
            check("busy_during_op", 64'(Busy), 64'd1);
            check("done_during_op", 64'(Done), 64'd0);
            if (junk) begin
                Start = 1'b1;
                A     = rand_bcd(1'b0);
                B     = rand_bcd(1'b0);
                Sub   = ~s;
            end else begin
                Start = 1'b0;
            end
            Cin = 1'($urandom);
            @(negedge Clock);
        end
        Start = 1'b0;
        check("done_pulse", 64'(Done), 64'd1);
        check("busy_at_done", 64'(Busy), 64'd0);
        check("err", 64'(Err), 64'(!valid));
        if (valid) begin
            check("sum", 64'(Sum), 64'(exp_sum));
            check("cout", 64'(Cout), 64'(exp_cout));
        end
        $display("op a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b err=%b", a, b, s, c, Sum, Cout, Err);
        @(negedge Clock);
        check("done_single_cycle", 64'(Done), 64'd0);
        if (junk) begin
            @(negedge Clock);
            check("no_queued_start_busy", 64'(Busy), 64'd0);
            check("no_queued_start_done", 64'(Done), 64'd0);
        end
    endtask

    initial begin
        int dones;
        Reset = 1'b1; Start = 1'b0; Sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge Clock);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_sum",  64'(Sum),  64'd0);
        check("rst_cout", 64'(Cout), 64'd0);
        check("rst_err",  64'(Err),  64'd0);
        Reset = 1'b0;

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h5000, 16'h1234, 1'b1, 1'b0, 1'b0);
        run_op(16'h1234, 16'h5000, 1'b1, 1'b1, 1'b0);
        run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h0042, 16'h0017, 1'b0, 1'b0, 1'b0);
        run_op(16'h2468, 16'h1357, 1'b0, 1'b1, 1'b1);

        // Start held high: two operations back to back at minimum spacing.
        @(negedge Clock);
        A = 16'h0500; B = 16'h0250; Sub = 1'b0; Cin = 1'b0; Start = 1'b1;
        dones = 0;
        for (int i = 0; i < 2 * D + 3; i++) begin
            @(negedge Clock);
            if (Done) dones++;
        end
        Start = 1'b0;
        check("b2b_done_count", 64'(dones), 64'd2);
        check("b2b_sum", 64'(Sum), 64'h0750);
        @(negedge Clock);

        // Reset mid-operation discards the in-flight result.
        @(negedge Clock);
        A = 16'h0003; B = 16'h0004; Sub = 1'b0; Cin = 1'b0; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_sum",  64'(Sum),  64'd0);
        check("midrst_cout", 64'(Cout), 64'd0);
        check("midrst_err",  64'(Err),  64'd0);
        dones = 0;
        for (int i = 0; i < D + 2; i++) begin
            @(negedge Clock);
            if (Done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++)
            run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
